// File: rtl/mod_inv.sv
// Sequential modular inverse r = a^-1 mod s (odd s) using binary extended Euclid, one step per clock.
// Optional RUN-cycle counter output enabled by MOD_INV_CYCLE_COUNT_EN.
module mod_inv #(
    parameter int unsigned FIELD_WIDTH = 16
`ifdef MOD_INV_CYCLE_COUNT_EN
    ,
    localparam int unsigned CYCLE_W = $clog2(4 * FIELD_WIDTH + 3)
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FIELD_WIDTH-1:0] a,
    input  logic [FIELD_WIDTH-1:0] s,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FIELD_WIDTH-1:0] r,
    output logic                   err
`ifdef MOD_INV_CYCLE_COUNT_EN
    ,
    output logic [CYCLE_W-1:0]     cycles
`endif
);

    localparam int unsigned W = FIELD_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   u, v, x1, x2, modulus;

    logic [W:0]     x1_ext, x2_ext, d12, d21;
    logic [W-1:0]   x1_half, x2_half, x1_sub, x2_sub, u_sub, v_sub;
    logic           illegal;

    // Halving and modular subtraction candidates for the current step.
    always_comb begin
        x1_ext  = {1'b0, x1} + (x1[0] ? {1'b0, modulus} : '0);
        x2_ext  = {1'b0, x2} + (x2[0] ? {1'b0, modulus} : '0);
        x1_half = x1_ext[W:1];
        x2_half = x2_ext[W:1];
        d12     = {1'b0, x1} - {1'b0, x2};
        d21     = {1'b0, x2} - {1'b0, x1};
        x1_sub  = d12[W] ? (d12[W-1:0] + modulus) : d12[W-1:0];
        x2_sub  = d21[W] ? (d21[W-1:0] + modulus) : d21[W-1:0];
        u_sub   = u - v;
        v_sub   = v - u;
        illegal = ~s[0] | (s < W'(3)) | (a == '0) | (a >= s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            err       <= 1'b0;
            u         <= '0;
            v         <= '0;
            x1        <= '0;
            x2        <= '0;
            modulus   <= '0;
`ifdef MOD_INV_CYCLE_COUNT_EN
            cycles    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        u        <= a;
                        v        <= s;
                        x1       <= W'(1);
                        x2       <= '0;
                        modulus  <= s;
                        in_ready <= 1'b0;
`ifdef MOD_INV_CYCLE_COUNT_EN
                        cycles   <= '0;
`endif
                        if (illegal) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            r         <= '0;
                            err       <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
`ifdef MOD_INV_CYCLE_COUNT_EN
                    cycles <= cycles + CYCLE_W'(1);
`endif
                    if (u == W'(1)) begin
                        r         <= x1;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (v == W'(1)) begin
                        r         <= x2;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if ((u == '0) || (v == '0)) begin
                        r         <= '0;
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= x1_half;
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= x2_half;
                    end else if (u >= v) begin
                        u  <= u_sub;
                        x1 <= x1_sub;
                    end else begin
                        v  <= v_sub;
                        x2 <= x2_sub;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_inv.sv
// Self-checking bench for mod_inv: directed cases, backpressure, mid-run reset and a random sweep
// against an ordinary extended-Euclid reference.
module tb_mod_inv;

    localparam int unsigned W = 16;
    localparam int MAX_RUN = 4 * W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         err;
`ifdef MOD_INV_CYCLE_COUNT_EN
    logic [$clog2(4*W+3)-1:0] cycles;
`endif

    int errors = 0;
    int checks = 0;

    mod_inv #(.FIELD_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .err       (err)
`ifdef MOD_INV_CYCLE_COUNT_EN
        ,
        .cycles    (cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: classic extended Euclid on integers, plus the operand legality rules.
    task automatic ref_inv(input longint ai, input longint si, output longint rr, output bit e);
        longint t, nt, rm, nrm, q, tmp;
        if ((si % 2 == 0) || (si < 3) || (ai == 0) || (ai >= si)) begin
            rr = 0;
            e  = 1'b1;
            return;
        end
        t = 0; nt = 1; rm = si; nrm = ai;
        while (nrm != 0) begin
            q = rm / nrm;
            tmp = t - q * nt;  t = nt;  nt = tmp;
            tmp = rm - q * nrm; rm = nrm; nrm = tmp;
        end
        if (rm != 1) begin
            rr = 0;
            e  = 1'b1;
        end else begin
            rr = (t < 0) ? t + si : t;
            e  = 1'b0;
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge where out_valid is seen.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] sv, output int n);
        check("in_ready_before_issue", longint'(in_ready), 1);
        a        = av;
        s        = sv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n <= MAX_RUN + 4) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_within_bound", longint'(out_valid), 1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handshake_out_valid_low", longint'(out_valid), 0);
        check("handshake_in_ready_high", longint'(in_ready), 1);
    endtask

    initial begin
        int          n;
        longint      er;
        bit          ee;
        logic [W-1:0] ra, rs;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        s         = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_r", longint'(r), 0);
        check("reset_err", longint'(err), 0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal: 3^-1 mod 7 = 5 in four RUN cycles.
        start_op(16'd3, 16'd7, n);
        check("nominal_r", longint'(r), 5);
        check("nominal_err", longint'(err), 0);
        check("nominal_run_cycles", n, 4);
`ifdef MOD_INV_CYCLE_COUNT_EN
        check("nominal_cycles_port", longint'(cycles), 4);
`endif
        finish_op();

        start_op(16'd1, 16'd7, n);
        check("identity_r", longint'(r), 1);
        check("identity_err", longint'(err), 0);
        check("identity_run_cycles", n, 1);
`ifdef MOD_INV_CYCLE_COUNT_EN
        check("identity_cycles_port", longint'(cycles), 1);
`endif
        finish_op();

        start_op(16'd6, 16'd9, n);
        check("noncoprime_err", longint'(err), 1);
        check("noncoprime_r", longint'(r), 0);
        finish_op();

        // Illegal operands finish one cycle after acceptance.
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin ra = 16'd1; rs = 16'd4; end
                1:       begin ra = 16'd0; rs = 16'd7; end
                default: begin ra = 16'd9; rs = 16'd7; end
            endcase
            start_op(ra, rs, n);
            check("illegal_err", longint'(err), 1);
            check("illegal_r", longint'(r), 0);
            check("illegal_latency", n, 0);
`ifdef MOD_INV_CYCLE_COUNT_EN
            check("illegal_cycles_port", longint'(cycles), 0);
`endif
            finish_op();
        end

        // Backpressure: result holds while out_ready is low, then back-to-back issue.
        start_op(16'd2, 16'd65521, n);
        for (int i = 0; i < 5; i++) begin
            check("bp_r_stable", longint'(r), 32761);
            check("bp_err", longint'(err), 0);
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_in_ready_low", longint'(in_ready), 0);
            in_valid = 1'b1;
            a = 16'd3;
            s = 16'd7;
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("bp_r_after_ignored_in", longint'(r), 32761);
        finish_op();
        start_op(16'd3, 16'd7, n);
        check("b2b_r", longint'(r), 5);
        finish_op();

        // Reset during the third RUN cycle aborts the computation.
        a = 16'd12345;
        s = 16'd65521;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_out_valid", longint'(out_valid), 0);
        check("midreset_r", longint'(r), 0);
        check("midreset_in_ready", longint'(in_ready), 1);
        check("midreset_err", longint'(err), 0);
        start_op(16'd12345, 16'd65521, n);
        ref_inv(12345, 65521, er, ee);
        check("post_reset_r", longint'(r), er);
        check("post_reset_err", longint'(err), longint'(ee));
        finish_op();

        // Random sweep over odd moduli.
        for (int i = 0; i < 1000; i++) begin
            rs = W'($urandom_range(1, 32767) * 2 + 1);
            if ($urandom_range(0, 15) == 0)
                ra = W'($urandom_range(0, 65535));
            else
                ra = W'($urandom_range(1, int'(rs) - 1));
            start_op(ra, rs, n);
            ref_inv(longint'(ra), longint'(rs), er, ee);
            check("rand_r", longint'(r), er);
            check("rand_err", longint'(err), longint'(ee));
            checks++;
            assert (n <= MAX_RUN)
            else begin
                errors++;
                $error("FAIL rand_run_cycles: observed=%0d limit=%0d", n, MAX_RUN);
            end
`ifdef MOD_INV_CYCLE_COUNT_EN
            check("rand_cycles_port", longint'(cycles), n);
`endif
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_inv.md
Name: mod_inv

Overview:
- Sequential modular inverse: r = a^-1 mod s, for an odd modulus s.
- Inverse direction of the modular multiplier. Used for field division and for affine conversion of projective points in the MSM datapath.
- Binary extended-Euclid algorithm, one step per clock.
- Valid/ready handshakes on both the input side and the output side.

Parameters:
- FIELD_WIDTH, 16, bit width of a, s and r.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands a and s are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  FIELD_WIDTH  element to invert; must satisfy a < s
- s  input  FIELD_WIDTH  modulus; must be odd and at least 3
- out_valid  output  1  r and err are valid
- out_ready  input  1  downstream accepts the result
- r  output  FIELD_WIDTH  inverse of a; 0 when err=1
- err  output  1  no inverse exists, or the operands are illegal

Behaviour:
- Reset: clk and reset as already decided (synchronous, active-high). In the reset cycle:
  - state goes to IDLE
  - in_ready=1, out_valid=0, r=0, err=0
  - internal registers u, v, x1, x2 cleared
  - reset mid-operation aborts the computation and discards any pending result.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the operands: u=a, v=s, x1=1, x2=0.
  - Go to RUN, unless the operands are illegal: s even, s<3, a==0 or a>=s. Illegal operands go directly to DONE with err=1, r=0.
- RUN: exactly one action per cycle, first matching rule wins:
  1. u==1: r<=x1, err<=0, go to DONE.
  2. v==1: r<=x2, err<=0, go to DONE.
  3. u==0 or v==0: gcd is not 1; r<=0, err<=1, go to DONE.
  4. u even: u<=u>>1; x1<=x1>>1 if x1 even, else (x1+s)>>1.
  5. v even: v<=v>>1; x2 updated in the same way as x1 in rule 4.
  6. u>=v: u<=u-v; x1<=x1-x2, adding s if the difference is negative.
  7. Otherwise: v<=v-u; x2<=x2-x1, adding s if the difference is negative.
- Width rules:
  - x1+s and x2+s are computed at FIELD_WIDTH+1 bits before the shift.
  - The subtractions use a FIELD_WIDTH+1 borrow bit.
  - Invariant: x1 and x2 always lie in [0, s).
- Latency: RUN lasts at most 4*FIELD_WIDTH+2 cycles. out_valid rises the cycle after the final RUN cycle.
- DONE:
  - out_valid=1; r and err stay stable until out_ready.
  - Handshake cycle (out_valid and out_ready both high): go to IDLE. in_ready=1 from the next cycle.
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
- r and err change only on entry to DONE or on reset.

Optional Feature:
- Macro: MOD_INV_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycles, width $clog2(4*FIELD_WIDTH+3).
  - The counter clears on input acceptance and increments each RUN cycle.
  - It holds its value in DONE and is valid with out_valid.
  - Illegal-operand results report cycles=0.
  - Reset value 0.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Nominal: a=3, s=7 -> r=5, err=0, 4 RUN cycles (cycles=4). Trace: sub, halve v, halve v, v==1.
- Identity: a=1, s=7 -> r=1, err=0, 1 RUN cycle.
- Non-coprime: a=6, s=9 -> err=1, r=0, reached via u==0.
- Illegal operands, each -> err=1, r=0, out_valid one cycle after acceptance, cycles=0:
  - s=4 (even)
  - a=0, s=7
  - a=9, s=7
- Backpressure and back-to-back operation:
  - Hold out_ready=0 for 5 cycles on a=2, s=65521 -> r=32761 stable, in_ready=0 throughout.
  - Release out_ready -> IDLE next cycle; the next operand is accepted immediately.
- Reset mid-RUN: a=12345, s=65521, assert reset on the 3rd RUN cycle -> next cycle out_valid=0, r=0, in_ready=1. A fresh request then completes correctly.
- Randomized sweep: FIELD_WIDTH=16, 1000 random (a, odd s) pairs -> (a*r) mod s == 1 whenever gcd=1, otherwise err=1. RUN cycles never exceed 66.
